// File: rtl/sumsq_pkg.sv
// Shared state encoding and width helpers for the sum-of-squares unit.
package sumsq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_A = 2'd1,
        SQ_B = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int LEN_DEFAULT = 16;

    // Operand width: half the radicand width.
    function automatic int rlen_of(input int len);
        return len / 2;
    endfunction

    // Accumulator width: one guard bit above the radicand so the sum never wraps.
    function automatic int acc_w_of(input int len);
        return len + 1;
    endfunction

    // Step counter width, never narrower than one bit.
    function automatic int cnt_w_of(input int len);
        return (len / 2 > 1) ? $clog2(len / 2) : 1;
    endfunction

endpackage

// File: rtl/sumsq_step.sv
// One shift-add squaring step: adds op<<k to the accumulator when op[k] is set.
module sumsq_step
    import sumsq_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT
)
(
    input  logic [acc_w_of(LEN)-1:0] acc,
    input  logic [rlen_of(LEN)-1:0]  op,
    input  logic [cnt_w_of(LEN)-1:0] k,
    output logic [acc_w_of(LEN)-1:0] acc_next
);

    localparam int AW = acc_w_of(LEN);

    logic [AW-1:0] op_ext;
    logic [AW-1:0] pp;

    // Partial product for bit k of the operand, added into the running sum
    always_comb begin
        op_ext   = AW'(op);
        pp       = op[k] ? (op_ext << k) : '0;
        acc_next = acc + pp;
    end

endmodule

// File: rtl/sumsq_seq.sv
// Sequential A^2 + B^2 with saturation, one partial product per cycle,
// valid/ready handshakes on both sides.
module sumsq_seq
    import sumsq_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [rlen_of(LEN)-1:0]  a,
    input  logic [rlen_of(LEN)-1:0]  b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LEN-1:0]           s,
    output logic                     ovf
);

    localparam int RLEN = rlen_of(LEN);
    localparam int AW   = acc_w_of(LEN);
    localparam int CW   = cnt_w_of(LEN);
    localparam logic [CW-1:0] K_LAST = CW'(RLEN - 1);

    state_t          state;
    state_t          state_next;
    logic [RLEN-1:0] op_a;
    logic [RLEN-1:0] op_b;
    logic [RLEN-1:0] op_cur;
    logic [CW-1:0]   k;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_next;
    logic            last_step;
    logic            accept;

    function automatic logic [LEN-1:0] saturate(input logic [AW-1:0] v);
        return v[LEN] ? {LEN{1'b1}} : v[LEN-1:0];
    endfunction

    // Ready is withheld while reset is asserted even though the state is IDLE.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign last_step = (k == K_LAST);
    assign op_cur    = (state == SQ_B) ? op_b : op_a;

    sumsq_step #(.LEN(LEN)) u_step (
        .acc      (acc),
        .op       (op_cur),
        .k        (k),
        .acc_next (acc_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SQ_A;
            SQ_A:    if (last_step) state_next = SQ_B;
            SQ_B:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Step counter, accumulator and result registers; the result is captured
    // from the final step's sum on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            k   <= '0;
            s   <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        k   <= '0;
                    end
                end
                SQ_A: begin
                    acc <= acc_next;
                    k   <= last_step ? '0 : k + CW'(1);
                end
                SQ_B: begin
                    acc <= acc_next;
                    if (last_step) begin
                        k   <= '0;
                        s   <= saturate(acc_next);
                        ovf <= acc_next[LEN];
                    end else begin
                        k   <= k + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture on the accept edge; later input changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= a;
            op_b <= b;
        end
    end

endmodule
